// File: rtl/bounce_pkg.sv
// Shared types and constants for the switch-bounce emulator family.
package bounce_pkg;

    // Burst sequencer states.
    typedef enum logic {
        IDLE   = 1'b0,
        BOUNCE = 1'b1
    } bounce_state_t;

    // Fibonacci taps 16,14,13,11 expressed as a mask over q[15:0].
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Nominal clock period, used to convert bounce times to cycles.
    localparam int T_CLK_NS = 10;

    // 10 ms bounce window at 100 MHz.
    localparam int DEF_BOUNCE_CYCLES = 1_000_000;

    // One shift of the 16-bit Fibonacci LFSR: feedback enters at bit 0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; only reset reloads the seed.
module lfsr16
    import bounce_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    logic [15:0] q_q;

    // Advance one step every cycle so the sequence depends only on time since reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= SEED;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            q_q <= lfsr_next(q_q);
        end
    end

    assign q = q_q;

endmodule

// File: rtl/switch_bounce_gen.sv
// Mechanical-switch emulator: each command edge gives a first contact,
// a window of pseudo-random toggles, then a forced settle to the new level.
module switch_bounce_gen
    import bounce_pkg::*;
#(
    parameter int          BOUNCE_CYCLES = DEF_BOUNCE_CYCLES,
    parameter int          SEG_W         = 12,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic cmd,
    output logic sw,
    output logic busy
);

    localparam int               WIN_W    = $clog2(BOUNCE_CYCLES + 1);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(BOUNCE_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [SEG_W-1:0] SEG_ONE  = SEG_W'(1);

    bounce_state_t    state_q, state_d;
    logic [1:0]       sync_q;
    logic             cmd_s;
    logic             level_q, level_d;
    logic             target_q, target_d;
    logic             sw_q, sw_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [15:0]      lfsr_q;
    logic [SEG_W-1:0] seg_rand;
    logic             lfsr_unused;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr_q)
    );

    // Segment lengths are odd, so a zero length can never be loaded.
    assign seg_rand    = lfsr_q[SEG_W-1:0] | SEG_ONE;
    // Only the low SEG_W bits feed the segment length here.
    assign lfsr_unused = &{1'b0, lfsr_q};

    assign cmd_s = sync_q[1];

    // Two-flop synchronizer for the asynchronous command.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], cmd};
        end
    end

    // Burst sequencer state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            level_q  <= 1'b0;
            target_q <= 1'b0;
            sw_q     <= 1'b0;
            win_q    <= '0;
            seg_q    <= SEG_ONE;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            target_q <= target_d;
            sw_q     <= sw_d;
            win_q    <= win_d;
            seg_q    <= seg_d;
        end
    end

    // Next-state logic. win_q counts the cycles left after the current one,
    // so the window spans exactly BOUNCE_CYCLES cycles and its final cycle
    // is the one with win_q == 0.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d  = state_q;
        level_d  = level_q;
        target_d = target_q;
        sw_d     = sw_q;
        win_d    = win_q;
        seg_d    = seg_q;
        busy     = 1'b0;

        unique case (state_q)
            IDLE: begin
                sw_d = level_q;
                if (!en) begin
                    level_d = cmd_s;
                    sw_d    = cmd_s;
                end else if (cmd_s != level_q) begin
                    target_d = cmd_s;
                    sw_d     = cmd_s;
                    win_d    = WIN_LOAD;
                    seg_d    = seg_rand;
                    state_d  = BOUNCE;
                end
            end

            BOUNCE: begin
                busy = 1'b1;
                if (win_q == '0) begin
                    // Settle wins over any toggle due on the same cycle.
                    sw_d    = target_q;
                    level_d = target_q;
                    state_d = IDLE;
                end else begin
                    win_d = win_q - WIN_ONE;
                    if (seg_q == SEG_ONE) begin
                        sw_d  = ~sw_q;
                        seg_d = seg_rand;
                    end else begin
                        seg_d = seg_q - SEG_ONE;
                    end
                end
            end
        endcase
    end

    assign sw = sw_q;

endmodule

// File: tb/tb_switch_bounce_gen.sv
// Scoreboard bench for switch_bounce_gen: an event-time reference model
// pushes the expected {sw, busy} every cycle; a monitor pops and compares.
module tb_switch_bounce_gen;

    localparam int          B    = 100;
    localparam int          SW_W = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic en    = 1'b0;
    logic cmd   = 1'b0;
    logic sw;
    logic busy;

    int checks = 0;
    int errors = 0;

    switch_bounce_gen #(
        .BOUNCE_CYCLES (B),
        .SEG_W         (SW_W),
        .SEED          (SEED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .cmd   (cmd),
        .sw    (sw),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic sw;
        logic busy;
    } out_t;

    out_t        exp_q[$];
    logic [15:0] m_lfsr   = SEED;
    logic [1:0]  m_sync   = 2'b00;
    logic        m_level  = 1'b0;
    logic        m_target = 1'b0;
    logic        m_sw     = 1'b0;
    logic        m_busy   = 1'b0;
    int          cyc      = 0;
    int          m_start, m_end, m_next;
    int          m_tog[$];
    int          ref_tog[$];
    int          dut_tog[$];

    function automatic logic [15:0] ref_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Segment length drawn from the low SW_W bits, forced odd.
    function automatic int seg_len(input logic [15:0] v);
        return (int'(v) % (1 << SW_W)) | 1;
    endfunction

    task automatic model_reset();
        m_lfsr   = SEED;
        m_sync   = 2'b00;
        m_level  = 1'b0;
        m_target = 1'b0;
        m_sw     = 1'b0;
        m_busy   = 1'b0;
        cyc      = 0;
        exp_q.delete();
    endtask

    // Toggles are scheduled as absolute cycle times: start + running sum of segment lengths.
    task automatic model_step();
        logic        cs = m_sync[1];
        logic [15:0] lf = m_lfsr;
        cyc++;
        if (!m_busy) begin
            if (!en) begin
                m_level = cs;
                m_sw    = cs;
            end else if (cs != m_level) begin
                m_target = cs;
                m_sw     = cs;
                m_busy   = 1'b1;
                m_start  = cyc;
                m_end    = cyc + B;
                m_next   = cyc + seg_len(lf);
                m_tog.delete();
            end
        end else if (cyc == m_end) begin
            if (m_sw != m_target) m_tog.push_back(cyc - m_start);
            m_sw    = m_target;
            m_level = m_target;
            m_busy  = 1'b0;
        end else if (cyc == m_next) begin
            m_sw = ~m_sw;
            m_tog.push_back(cyc - m_start);
            m_next = cyc + seg_len(lf);
        end
        m_sync = {m_sync[0], cmd};
        m_lfsr = ref_step(lf);
        exp_q.push_back('{sw: m_sw, busy: m_busy});
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_reset();
            else       model_step();
        end
    end

    // Monitor: one expected sample per clock, compared away from the active edge.
    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            if (!reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb_sw", sw, e.sw);
                check("sb_busy", busy, e.busy);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cmd   = 1'b0;
        en    = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic wait_busy(input logic val, input int limit);
        int n = 0;
        while (busy !== val && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("wait_busy", busy, val);
    endtask

    // Called right after cmd is driven: records latency, window width and
    // sw change offsets relative to the first contact.
    task automatic observe_burst(output int lat, output int width);
        int   n = 0;
        int   n0 = 0;
        logic started = 1'b0;
        logic done = 1'b0;
        logic psw = sw;
        width = 0;
        dut_tog.delete();
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
            if (!started) begin
                if (busy) begin
                    started = 1'b1;
                    n0      = n;
                    width   = 1;
                end
            end else begin
                if (sw != psw) dut_tog.push_back(n - n0);
                if (busy) width++;
                else      done = 1'b1;
            end
            psw = sw;
        end
        lat = n0;
        check("burst_done", done, 1'b1);
    endtask

    task automatic compare_tog(input string name, input int exp_list[$]);
        check({name, "_count"}, dut_tog.size(), exp_list.size());
        for (int i = 0; i < dut_tog.size() && i < exp_list.size(); i++)
            check({name, "_cycle"}, dut_tog[i], exp_list[i]);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   lat, width, nchg, nbusy;
        logic psw;
        logic hist[0:99];

        // Quiet line after reset: no activity at all.
        do_reset();
        check("rst_sw", sw, 1'b0);
        check("rst_busy", busy, 1'b0);
        nchg = 0; nbusy = 0; psw = sw;
        repeat (1000) begin
            @(negedge clk);
            if (sw != psw) nchg++;
            if (busy) nbusy++;
            psw = sw;
        end
        check("quiet_changes", nchg, 0);
        check("quiet_busy", nbusy, 0);

        // Single 0->1 burst from a fresh seed.
        do_reset();
        repeat (5) @(negedge clk);
        cmd = 1'b1;
        observe_burst(lat, width);
        check("first_contact_latency", lat, 3);
        check("busy_width", width, B);
        check("toggles_ge5", dut_tog.size() >= 5, 1'b1);
        compare_tog("burst_tog", m_tog);
        ref_tog = m_tog;
        repeat (30) @(negedge clk);
        check("settled_sw", sw, 1'b1);

        // Bypass: sw follows cmd three edges later, busy stays low.
        @(negedge clk);
        en = 1'b0;
        for (int k = 0; k < 84; k++) begin
            @(negedge clk);
            if (k >= 3) check("bypass_sw", sw, hist[k-3]);
            check("bypass_busy", busy, 1'b0);
            if (k % 7 == 0) cmd = ~cmd;
            hist[k] = cmd;
        end

        // Reversal mid-window: first burst settles high, second starts one cycle later.
        cmd = 1'b0;
        repeat (5) @(negedge clk);
        en = 1'b1;
        repeat (3) @(negedge clk);
        cmd = 1'b1;
        wait_busy(1'b1, 10);
        repeat (20) @(negedge clk);
        cmd = 1'b0;
        wait_busy(1'b0, 200);
        check("rev_first_final", sw, 1'b1);
        @(negedge clk);
        check("rev_gap_busy", busy, 1'b1);
        check("rev_second_contact", sw, 1'b0);
        wait_busy(1'b0, 200);
        check("rev_second_final", sw, 1'b0);

        // Reset mid-burst aborts at once; re-issued command replays the seed sequence.
        repeat (3) @(negedge clk);
        cmd = 1'b1;
        wait_busy(1'b1, 10);
        repeat (50) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_sw", sw, 1'b0);
        check("abort_busy", busy, 1'b0);
        do_reset();
        repeat (5) @(negedge clk);
        cmd = 1'b1;
        observe_burst(lat, width);
        check("replay_latency", lat, 3);
        check("replay_width", width, B);
        compare_tog("replay_tog", ref_tog);

        // Randomized command / enable traffic against the model.
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            en  = ($urandom_range(0, 3) != 0);
            cmd = $urandom_range(0, 1);
            repeat ($urandom_range(1, 150)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
